// File: rtl/perf_cnt_uart_dump_pkg.sv
// Shared constants for the cache event-counter UART dump: FSM state codes,
// 8N1 framing constants and the default frame sync byte.
package perf_cnt_uart_dump_pkg;

    localparam int         UART_FRAME_BITS   = 10;
    localparam logic       UART_START_BIT    = 1'b0;
    localparam logic       UART_STOP_BIT     = 1'b1;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_SYNC    = 3'd1;
    localparam state_t S_FETCH   = 3'd2;
    localparam state_t S_CAPTURE = 3'd3;
    localparam state_t S_SEND    = 3'd4;
    localparam state_t S_CSUM    = 3'd5;
    localparam state_t S_DONE    = 3'd6;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/perf_cnt_uart_dump_uart_tx_byte.sv
// 8N1 byte serializer. ready_o is also high in the last cycle of the stop
// bit, so a byte offered then starts its start bit on the very next cycle.
module uart_tx_byte
    import perf_cnt_uart_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic                 active_q, active_d;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [UART_FRAME_BITS-1:0] shift_q, shift_d;
    logic                 bit_end;
    logic                 last_bit;

    assign bit_end  = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
    assign last_bit = (bit_idx_q == 4'(UART_FRAME_BITS - 1));
    assign ready_o  = !active_q || (bit_end && last_bit);
    assign tx_o     = active_q ? shift_q[0] : UART_STOP_BIT;

    // Next-state: load a new frame on handshake, otherwise time and shift bits.
    always_comb begin
        active_d  = active_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        if (valid_i && ready_o) begin
            active_d  = 1'b1;
            shift_d   = {UART_STOP_BIT, data_i, UART_START_BIT};
            clk_cnt_d = '0;
            bit_idx_d = '0;
        end else if (active_q) begin
            if (bit_end) begin
                clk_cnt_d = '0;
                if (last_bit) begin
                    active_d = 1'b0;
                end else begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    shift_d   = {UART_STOP_BIT, shift_q[UART_FRAME_BITS-1:1]};
                end
            end else begin
                clk_cnt_d = clk_cnt_q + 1'b1;
            end
        end
    end

    // Serializer state registers; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active_q  <= 1'b0;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '1;
        end else begin
            active_q  <= active_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

endmodule

// File: rtl/perf_cnt_uart_dump.sv
// Counter-bank readback: snapshots each counter through the registered
// select/read port and streams SYNC, counter bytes (LSB first) and an XOR
// checksum out of a single UART TX pin.
//
// state   | meaning
// IDLE    | waiting for start_i; SYNC byte is handed to the serializer on start
// SYNC    | SYNC byte on the line
// FETCH   | cnt_sel_o/cnt_rd_o drive the bank read (line idle)
// CAPTURE | cnt_data_i snapshotted; its low byte goes straight to the serializer
// SEND    | remaining snapshot bytes, then next counter or checksum
// CSUM    | checksum byte on the line
// DONE    | done_o pulse, busy_o already low
module perf_cnt_uart_dump
    import perf_cnt_uart_dump_pkg::*;
#(
    parameter int         N_CNT        = 9,
    parameter int         CNT_W        = 32,
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start_i,
    output logic [clog2_min1(N_CNT)-1:0] cnt_sel_o,
    output logic                         cnt_rd_o,
    input  logic [CNT_W-1:0]             cnt_data_i,
    output logic                         tx_o,
    output logic                         busy_o,
    output logic                         done_o
);
    localparam int SEL_W   = clog2_min1(N_CNT);
    localparam int N_BYTES = CNT_W / 8;
    localparam int BI_W    = clog2_min1(N_BYTES);

    if ((CNT_W % 8) != 0 || N_CNT < 1 || CLKS_PER_BIT < 2) begin : g_bad_params
        $error("perf_cnt_uart_dump: illegal parameters (CNT_W%%8, N_CNT, CLKS_PER_BIT)");
    end

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
    logic              sent_q, sent_d;
    logic [CNT_W-1:0]  snap_q, snap_d;
    logic [7:0]        csum_q, csum_d;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;

    assign cnt_sel_o = idx_q;
    assign cnt_rd_o  = (state_q == S_FETCH);
    assign done_o    = (state_q == S_DONE);
    assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rstn   (rstn),
        .valid_i(tx_valid),
        .data_i (tx_data),
        .ready_o(tx_ready),
        .tx_o   (tx_o)
    );

    // Frame sequencing. Bytes are offered at the serializer's last stop-bit
    // cycle so the line has no gap, except the FETCH/CAPTURE pair per counter.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        byte_idx_d = byte_idx_q;
        sent_d     = sent_q;
        snap_d     = snap_q;
        csum_d     = csum_q;
        tx_valid   = 1'b0;
        tx_data    = SYNC_BYTE;
        case (state_q)
            S_IDLE: begin
                if (start_i && tx_ready) begin
                    tx_valid = 1'b1;
                    csum_d   = '0;
                    state_d  = S_SYNC;
                end
            end
            S_SYNC: begin
                if (tx_ready) begin
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                tx_valid   = 1'b1;
                tx_data    = cnt_data_i[7:0];
                csum_d     = csum_q ^ cnt_data_i[7:0];
                snap_d     = cnt_data_i >> 8;
                byte_idx_d = BI_W'(1);
                sent_d     = (N_BYTES == 1);
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (tx_ready) begin
                    if (!sent_q) begin
                        tx_valid   = 1'b1;
                        tx_data    = snap_q[7:0];
                        csum_d     = csum_q ^ snap_q[7:0];
                        snap_d     = snap_q >> 8;
                        byte_idx_d = byte_idx_q + 1'b1;
                        sent_d     = (byte_idx_q == BI_W'(N_BYTES - 1));
                    end else if (idx_q == SEL_W'(N_CNT - 1)) begin
                        tx_valid = 1'b1;
                        tx_data  = csum_q;
                        state_d  = S_CSUM;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_CSUM: begin
                if (tx_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM, index, snapshot and checksum registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            byte_idx_q <= '0;
            sent_q     <= 1'b0;
            snap_q     <= '0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_idx_q <= byte_idx_d;
            sent_q     <= sent_d;
            snap_q     <= snap_d;
            csum_q     <= csum_d;
        end
    end

endmodule

// File: tb/tb_perf_cnt_uart_dump.sv
// Bench for perf_cnt_uart_dump: two instances (2 and 9 counters, 4 clocks
// per bit) fed by a registered counter-bank model; the TX line is recorded
// and decoded, then compared with a frame built from the counter values.
`timescale 1ns/1ps
module tb_perf_cnt_uart_dump;
    localparam int CPB      = 4;
    localparam int BYTE_CYC = 10 * CPB;
    localparam int NA       = 2;
    localparam int NB       = 9;

    logic        clk;
    logic        rstn;
    logic        start_a, start_b;
    logic [0:0]  sel_a;
    logic [3:0]  sel_b;
    logic        rd_a, rd_b;
    logic [31:0] data_a, data_b;
    logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;

    logic [31:0] bank_a [NA];
    logic [31:0] bank_b [NB];
    logic [0:0]  rsel_a = '0;
    logic [3:0]  rsel_b = '0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic       trace[$];
    logic [7:0] dec_bytes[$];
    int         dec_gaps[$];
    logic [7:0] exp_bytes[$];
    int         sels[$];
    int         width_err, busy_cyc, done_cnt, done_bad;
    bit         timed_out;
    logic       rst_tx, rst_busy, rst_done, rst_rd;
    int         rst_sel;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    perf_cnt_uart_dump #(.N_CNT(NA), .CNT_W(32), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut_a (
        .clk(clk), .rstn(rstn), .start_i(start_a), .cnt_sel_o(sel_a), .cnt_rd_o(rd_a),
        .cnt_data_i(data_a), .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a));

    perf_cnt_uart_dump #(.N_CNT(NB), .CNT_W(32), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut_b (
        .clk(clk), .rstn(rstn), .start_i(start_b), .cnt_sel_o(sel_b), .cnt_rd_o(rd_b),
        .cnt_data_i(data_b), .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b));

    // Bank model: the select is registered on the read strobe, data follows the live counter.
    always @(posedge clk) begin
        if (rd_a) rsel_a <= sel_a;
        if (rd_b) rsel_b <= sel_b;
    end
    assign data_a = bank_a[rsel_a];
    assign data_b = (rsel_b < 4'(NB)) ? bank_b[rsel_b] : 32'h0;

    task automatic sample(input int which, output logic tx, output logic busy,
                          output logic done, output logic rd, output int sel);
        tx   = (which == 0) ? tx_a   : tx_b;
        busy = (which == 0) ? busy_a : busy_b;
        done = (which == 0) ? done_a : done_b;
        rd   = (which == 0) ? rd_a   : rd_b;
        sel  = (which == 0) ? int'(sel_a) : int'(sel_b);
    endtask

    task automatic drive_start(input int which, input logic v);
        if (which == 0) start_a = v;
        else            start_b = v;
    endtask

    // Expected frame straight from the byte-level rules.
    task automatic model_frame(input int which, input int n);
        logic [31:0] v;
        logic [7:0]  cs;
        exp_bytes.delete();
        cs = 8'h00;
        exp_bytes.push_back(8'hA5);
        for (int i = 0; i < n; i++) begin
            v = (which == 0) ? bank_a[i] : bank_b[i];
            for (int b = 0; b < 4; b++) begin
                exp_bytes.push_back(v[8*b +: 8]);
                cs = cs ^ v[8*b +: 8];
            end
        end
        exp_bytes.push_back(cs);
    endtask

    // Pulse start, then record the line cycle by cycle until done (+60) or budget.
    task automatic run_frame(input int which, input int n, input int restart_at,
                             input int reset_at, input bit mod0);
        logic tx, busy, done, rd, prev_busy;
        int   sel, budget, after, mod_cd;
        trace.delete();
        sels.delete();
        busy_cyc = 0; done_cnt = 0; done_bad = 0; timed_out = 1'b1;
        prev_busy = 1'b0; after = 0; mod_cd = 0;
        budget = (2 + n * 4) * BYTE_CYC + n * 2 + 200;
        @(posedge clk); #1 drive_start(which, 1'b1);
        @(posedge clk); #1 drive_start(which, 1'b0);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            sample(which, tx, busy, done, rd, sel);
            if (c == reset_at) begin
                rstn = 1'b0;
                #1;
                sample(which, rst_tx, rst_busy, rst_done, rst_rd, rst_sel);
                timed_out = 1'b0;
                break;
            end
            trace.push_back(tx);
            if (busy) busy_cyc++;
            if (rd) sels.push_back(sel);
            if (done) begin
                done_cnt++;
                if (busy || !prev_busy) done_bad++;
            end
            prev_busy = busy;
            if (c == restart_at)     drive_start(which, 1'b1);
            if (c == restart_at + 1) drive_start(which, 1'b0);
            if (mod0) begin
                if (rd && sel == 0) mod_cd = 2;
                else if (mod_cd > 0) begin
                    mod_cd--;
                    if (mod_cd == 0) bank_a[0] = 32'hFFFF_FFFF;
                end
            end
            if (done_cnt > 0) begin
                after++;
                if (after > 60) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
    endtask

    // UART decode of the recorded line; every bit must hold for CPB samples.
    task automatic decode();
        int i, gap;
        logic [7:0] b;
        dec_bytes.delete(); dec_gaps.delete();
        width_err = 0; i = 0; gap = 0;
        while (i < trace.size()) begin
            if (trace[i] == 1'b1) begin
                gap++; i++;
            end else if (i + BYTE_CYC > trace.size()) begin
                width_err++; i = trace.size();
            end else begin
                for (int g = 0; g < 10; g++)
                    for (int c = 1; c < CPB; c++)
                        if (trace[i + g*CPB + c] !== trace[i + g*CPB]) width_err++;
                if (trace[i + 9*CPB] !== 1'b1) width_err++;
                for (int k = 0; k < 8; k++) b[k] = trace[i + (k+1)*CPB];
                dec_bytes.push_back(b);
                dec_gaps.push_back(gap);
                gap = 0;
                i += BYTE_CYC;
            end
        end
    endtask

    function automatic int bytes_bad();
        if (dec_bytes.size() != exp_bytes.size()) return -2;
        for (int k = 0; k < dec_bytes.size(); k++)
            if (dec_bytes[k] !== exp_bytes[k]) return k;
        return -1;
    endfunction

    // Gap before byte k (k>=1): 2 idle cycles ahead of each counter's first byte, else none.
    function automatic int gaps_bad(input int n);
        for (int k = 1; k < dec_gaps.size(); k++)
            if (dec_gaps[k] != (((k <= n*4) && ((k-1) % 4 == 0)) ? 2 : 0)) return k;
        return -1;
    endfunction

    function automatic int sels_bad(input int n);
        if (sels.size() != n) return -2;
        for (int k = 0; k < n; k++) if (sels[k] != k) return k;
        return -1;
    endfunction

    task automatic test_reset();
        int bt, bb, bd, br, bs;
        rstn = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({tx_a, tx_b, busy_a, busy_b, done_a, done_b, rd_a, rd_b} !== 8'b1100_0000)
            $display("FAIL reset_hold: got %b want 11000000",
                     {tx_a, tx_b, busy_a, busy_b, done_a, done_b, rd_a, rd_b});
        else pass_cnt++;
        rstn = 1'b1;
        bt = 0; bb = 0; bd = 0; br = 0; bs = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || tx_b !== 1'b1) bt++;
            if (busy_a !== 1'b0 || busy_b !== 1'b0) bb++;
            if (done_a !== 1'b0 || done_b !== 1'b0) bd++;
            if (rd_a !== 1'b0 || rd_b !== 1'b0) br++;
            if (sel_a !== 1'b0 || sel_b !== 4'd0) bs++;
        end
        total_cnt++; if (bt != 0) $display("FAIL idle_tx: %0d bad cycles want 0", bt); else pass_cnt++;
        total_cnt++; if (bb != 0) $display("FAIL idle_busy: %0d bad cycles want 0", bb); else pass_cnt++;
        total_cnt++; if (bd != 0) $display("FAIL idle_done: %0d bad cycles want 0", bd); else pass_cnt++;
        total_cnt++; if (br != 0) $display("FAIL idle_rd: %0d bad cycles want 0", br); else pass_cnt++;
        total_cnt++; if (bs != 0) $display("FAIL idle_sel: %0d bad cycles want 0", bs); else pass_cnt++;
    endtask

    task automatic test_known_frame();
        logic [7:0] known [10];
        int d;
        known = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h66};
        bank_a[0] = 32'h1122_3344; bank_a[1] = 32'hDEAD_BEEF;
        exp_bytes.delete();
        for (int k = 0; k < 10; k++) exp_bytes.push_back(known[k]);
        run_frame(0, NA, -1, -1, 1'b0);
        decode();
        total_cnt++; if (timed_out) $display("FAIL known_timeout: done %0d want 1", done_cnt); else pass_cnt++;
        total_cnt++; if (bytes_bad() != -1) $display("FAIL known_bytes: at %0d, got %0d bytes want 10", bytes_bad(), dec_bytes.size()); else pass_cnt++;
        total_cnt++; if (width_err != 0) $display("FAIL known_bit_width: %0d errors want 0", width_err); else pass_cnt++;
        total_cnt++; if (gaps_bad(NA) != -1) $display("FAIL known_gaps: byte %0d gap wrong", gaps_bad(NA)); else pass_cnt++;
        total_cnt++; if (done_cnt != 1) $display("FAIL known_done_count: got %0d want 1", done_cnt); else pass_cnt++;
        total_cnt++; if (done_bad != 0) $display("FAIL known_done_busy: got %0d bad want 0", done_bad); else pass_cnt++;
        d = busy_cyc - (10 * BYTE_CYC + NA * 2);
        total_cnt++; if (d < -2 || d > 2) $display("FAIL known_busy_len: got %0d want %0d", busy_cyc, 10 * BYTE_CYC + NA * 2); else pass_cnt++;
        total_cnt++; if (sels_bad(NA) != -1) $display("FAIL known_sel_seq: at %0d got %0d reads want %0d", sels_bad(NA), sels.size(), NA); else pass_cnt++;
    endtask

    task automatic test_snapshot();
        logic [7:0] known [10];
        known = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h66};
        bank_a[0] = 32'h1122_3344; bank_a[1] = 32'hDEAD_BEEF;
        exp_bytes.delete();
        for (int k = 0; k < 10; k++) exp_bytes.push_back(known[k]);
        run_frame(0, NA, -1, -1, 1'b1);
        decode();
        total_cnt++; if (timed_out) $display("FAIL snap_timeout: done %0d want 1", done_cnt); else pass_cnt++;
        total_cnt++; if (bytes_bad() != -1) $display("FAIL snap_bytes: at %0d, got %0d bytes want 10", bytes_bad(), dec_bytes.size()); else pass_cnt++;
    endtask

    task automatic test_restart_ignored();
        int d;
        bank_a[0] = $urandom; bank_a[1] = $urandom;
        model_frame(0, NA);
        run_frame(0, NA, 130, -1, 1'b0);
        decode();
        total_cnt++; if (bytes_bad() != -1) $display("FAIL restart_bytes: at %0d got %0d bytes want %0d", bytes_bad(), dec_bytes.size(), exp_bytes.size()); else pass_cnt++;
        total_cnt++; if (done_cnt != 1) $display("FAIL restart_done_count: got %0d want 1", done_cnt); else pass_cnt++;
        total_cnt++; if (sels.size() != NA) $display("FAIL restart_reads: got %0d want %0d", sels.size(), NA); else pass_cnt++;
        d = busy_cyc - (exp_bytes.size() * BYTE_CYC + NA * 2);
        total_cnt++; if (d < -2 || d > 2) $display("FAIL restart_busy_len: got %0d want %0d", busy_cyc, exp_bytes.size() * BYTE_CYC + NA * 2); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        bank_a[0] = $urandom; bank_a[1] = $urandom;
        // byte 2 starts at cycle 82; data bit 5 occupies cycles 106..109
        run_frame(0, NA, -1, 107, 1'b0);
        total_cnt++;
        if ({rst_tx, rst_busy, rst_done, rst_rd} !== 4'b1000)
            $display("FAIL midreset_outputs: tx/busy/done/rd got %b want 1000", {rst_tx, rst_busy, rst_done, rst_rd});
        else pass_cnt++;
        total_cnt++; if (rst_sel != 0) $display("FAIL midreset_sel: got %0d want 0", rst_sel); else pass_cnt++;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        model_frame(0, NA);
        run_frame(0, NA, -1, -1, 1'b0);
        decode();
        total_cnt++; if (bytes_bad() != -1) $display("FAIL midreset_frame: at %0d got %0d bytes want %0d", bytes_bad(), dec_bytes.size(), exp_bytes.size()); else pass_cnt++;
        total_cnt++; if (done_cnt != 1) $display("FAIL midreset_done: got %0d want 1", done_cnt); else pass_cnt++;
    endtask

    task automatic test_full_bank_zero();
        int bad, d;
        for (int i = 0; i < NB; i++) bank_b[i] = 32'h0;
        run_frame(1, NB, -1, -1, 1'b0);
        decode();
        bad = 0;
        for (int k = 0; k < dec_bytes.size(); k++)
            if (dec_bytes[k] !== ((k == 0) ? 8'hA5 : 8'h00)) bad++;
        total_cnt++; if (dec_bytes.size() != 38) $display("FAIL zero_len: got %0d want 38", dec_bytes.size()); else pass_cnt++;
        total_cnt++; if (bad != 0) $display("FAIL zero_bytes: %0d wrong want 0", bad); else pass_cnt++;
        total_cnt++; if (gaps_bad(NB) != -1) $display("FAIL zero_gaps: byte %0d gap wrong", gaps_bad(NB)); else pass_cnt++;
        d = busy_cyc - (38 * BYTE_CYC + NB * 2);
        total_cnt++; if (d < -2 || d > 2) $display("FAIL zero_busy_len: got %0d want %0d", busy_cyc, 38 * BYTE_CYC + NB * 2); else pass_cnt++;
        total_cnt++; if (sels_bad(NB) != -1) $display("FAIL zero_sel_seq: at %0d got %0d reads want %0d", sels_bad(NB), sels.size(), NB); else pass_cnt++;
        total_cnt++; if (done_cnt != 1 || done_bad != 0) $display("FAIL zero_done: count %0d bad %0d want 1/0", done_cnt, done_bad); else pass_cnt++;
    endtask

    task automatic test_random_frames();
        int which, n, d;
        for (int it = 0; it < 4; it++) begin
            which = (it == 3) ? 1 : 0;
            n = (which == 0) ? NA : NB;
            for (int i = 0; i < n; i++) begin
                if (which == 0) bank_a[i] = (it == 0) ? ((i == 0) ? 32'hFFFF_FFFF : 32'h0) : $urandom;
                else            bank_b[i] = $urandom;
            end
            model_frame(which, n);
            run_frame(which, n, -1, -1, 1'b0);
            decode();
            total_cnt++; if (bytes_bad() != -1) $display("FAIL rand%0d_bytes: at %0d got %0d bytes want %0d", it, bytes_bad(), dec_bytes.size(), exp_bytes.size()); else pass_cnt++;
            total_cnt++; if (width_err != 0 || gaps_bad(n) != -1) $display("FAIL rand%0d_timing: width errors %0d gap byte %0d want 0/-1", it, width_err, gaps_bad(n)); else pass_cnt++;
            d = busy_cyc - (exp_bytes.size() * BYTE_CYC + n * 2);
            total_cnt++; if (d < -2 || d > 2 || done_cnt != 1) $display("FAIL rand%0d_busy: got %0d cycles %0d done want %0d/1", it, busy_cyc, done_cnt, exp_bytes.size() * BYTE_CYC + n * 2); else pass_cnt++;
        end
    endtask

    initial begin
        rstn = 1'b0; start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < NA; i++) bank_a[i] = 32'h0;
        for (int i = 0; i < NB; i++) bank_b[i] = 32'h0;
        test_reset();
        test_known_frame();
        test_snapshot();
        test_restart_ignored();
        test_reset_mid_frame();
        test_full_bank_zero();
        test_random_frames();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/perf_cnt_uart_dump.md
Name: perf_cnt_uart_dump

Overview:
Readback side of the cache event-counter bank. On a start pulse it reads every counter through a registered select/read port and snapshots each value. It then streams the frame out on a single UART TX pin (8N1) so miss/access statistics leave the FPGA without a logic analyser. It sits beside the counter on the memory clock domain and replaces the 8-bit parallel data_o observation path.

Parameters:
N_CNT, 9, number of counters in the bank (L1I read/miss, L1D read/write/miss, L2 read/write/miss, spare)
CNT_W, 32, counter width in bits; must be a multiple of 8
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200)
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  in  1  memory-domain clock
rstn  in  1  asynchronous active-low reset
start_i  in  1  single-cycle dump request
cnt_sel_o  out  $clog2(N_CNT)  counter index being read
cnt_rd_o  out  1  read strobe; cnt_data_i is valid the cycle after
cnt_data_i  in  CNT_W  counter value from bank
tx_o  out  1  UART serial out, idle high
busy_o  out  1  frame in progress
done_o  out  1  one-cycle pulse after final stop bit

Behaviour:
- Reset (async, rstn=0): tx_o=1, busy_o=0, done_o=0, cnt_rd_o=0, cnt_sel_o=0. FSM goes to IDLE and the byte serializer is cleared. Applies immediately, even mid-bit.
- Frame: SYNC_BYTE, then for idx=0..N_CNT-1 the CNT_W/8 bytes of counter idx, least-significant byte first, then CSUM.
  - CSUM = XOR of all bytes after SYNC_BYTE.
  - Frame length = 2 + N_CNT*CNT_W/8 bytes.
- UART byte format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
- Inter-byte spacing:
  - Within the frame, the next start bit begins the cycle after the previous stop bit ends (zero idle gap).
  - Exception: before each counter's first byte there is a 2-cycle fetch gap with tx_o=1.
- FSM states: IDLE, SYNC, FETCH, CAPTURE, SEND, CSUM, DONE.
  - IDLE: on start_i=1, busy_o←1 and go to SYNC.
  - SYNC: send SYNC_BYTE; on completion go to FETCH with idx=0.
  - FETCH (1 cycle): cnt_sel_o=idx, cnt_rd_o=1.
  - CAPTURE (1 cycle): latch cnt_data_i into the snapshot register.
  - SEND: shift out the CNT_W/8 snapshot bytes, XOR-ing each into the checksum. Then if idx==N_CNT-1 go to CSUM, else idx++ and go to FETCH.
  - CSUM: send the checksum byte.
  - DONE (1 cycle): done_o=1, busy_o←0, go to IDLE.
- Snapshot rule: later changes to the counter do not alter the bytes being sent for that counter.
- start_i while busy_o=1 is ignored; it is neither queued nor restarting.
- start_i in the same cycle as the DONE pulse is ignored; a new request is accepted from the following cycle.
- cnt_sel_o holds its last value outside FETCH. cnt_rd_o is high only in FETCH.
- Width rules:
  - Checksum register is 8 bits.
  - Bit-time counter is $clog2(CLKS_PER_BIT) bits and wraps to 0 at CLKS_PER_BIT-1.
  - Byte index within a counter is $clog2(CNT_W/8) bits, minimum 1.
- Elaboration error if CNT_W%8≠0, N_CNT<1 or CLKS_PER_BIT<2.

Decomposition:
- Shared package: FSM state enum, UART framing constants (start=0, stop=1, 10 bits/byte), SYNC_BYTE default.
- One sub-module: uart_tx_byte.
  - Ports: clk, rstn, valid_i, data_i[7:0], ready_o, tx_o.
  - Accepts a byte when valid_i & ready_o. ready_o rises in the final cycle of the stop bit, which gives the zero-gap back-to-back behaviour.
- Top holds the FSM, snapshot register, index counters and checksum.

Test Plan:
1. Reset: hold rstn=0, then release with no start -> tx_o=1, busy_o=0, done_o=0, cnt_rd_o=0 for 100 cycles.
2. N_CNT=2, CNT_W=32, CLKS_PER_BIT=4, counters 0x11223344 and 0xDEADBEEF, pulse start_i.
   - Decoded bytes: A5 44 33 22 11 EF BE AD DE 66.
   - Each bit is exactly 4 cycles; the 2-cycle gaps appear only before bytes 44 and EF.
   - done_o pulses once; busy_o drops in the same cycle.
3. Same setup, change counter 0 to 0xFFFFFFFF the cycle after CAPTURE -> bytes are still 44 33 22 11, CSUM 66.
4. Pulse start_i again at byte 3 of a frame -> one frame only, one done_o pulse, no second cnt_rd_o burst.
5. Assert rstn=0 in the middle of data bit 5 of byte 2 -> tx_o=1 within the same cycle, busy_o=0. After release and a new start, a complete correct frame beginning with A5.
6. N_CNT=9, counters all zero -> 38 bytes: A5, 36×00, CSUM 00. busy_o stays high for 38×40 + 9×2 cycles ± 2.
